spi_reg_responder: RTL

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_reg_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register responder: FSM states and command field layout.
package spi_pkg;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned ADDR_W     = 3;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, plus single-cycle rise/fall pulses
// taken from the synchronized value.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 target exposing a small bank of 8-bit registers with burst read/write access.
// Command byte: bit7 = read, bits[2:0] = start address; data bytes follow with auto-increment.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NREGS       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [7:0]        reg0,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(NREGS - 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_VAL    (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_VAL    (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // mosi gets the same depth so it stays aligned with the sclk edge pulses.
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_q <= '0;
    end else begin
      mosi_q[0] <= mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mosi_q[i] <= mosi_q[i-1];
      end
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        rx_q;
  logic [7:0]        tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              miso_q;
  logic [7:0]        regs_q [NREGS];
  logic              wr_strobe_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              cmd_done;
  logic              byte_done;

  assign rx_byte  = {rx_q, mosi_s};
  assign cmd_addr = rx_byte[ADDR_W-1:0] & AddrMask;
  assign addr_inc = (addr_q + ADDR_W'(1)) & AddrMask;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cs_fall) state_d = StCmd;
      StCmd: begin
        if (cs_rise) begin
          state_d = StIdle;
        end else if (cmd_done) begin
          state_d = StData;
        end
      end
      StData: if (cs_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_done  = (state_q == StCmd)  && sclk_rise && (bit_cnt_q == 3'd7);
    byte_done = (state_q == StData) && sclk_rise && (bit_cnt_q == 3'd7);
    miso_oe   = (state_q != StIdle);
  end

  // Shift datapath: rx on sclk rise, tx on sclk fall; cs edges discard any partial byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      miso_q    <= 1'b0;
    end else if (cs_fall || cs_rise) begin
      bit_cnt_q <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
    end else if (state_q != StIdle) begin
      if (sclk_rise) begin
        rx_q      <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (cmd_done) begin
          rd_q   <= rx_byte[CMD_RW_BIT];
          addr_q <= cmd_addr;
          tx_q   <= rx_byte[CMD_RW_BIT] ? regs_q[cmd_addr] : 8'h00;
        end else if (byte_done) begin
          addr_q <= addr_inc;
          tx_q   <= rd_q ? regs_q[addr_inc] : 8'h00;
        end
      end else if (sclk_fall) begin
        miso_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
    end
  end

  // Register file; a write completing alongside a cs_n rise still commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (byte_done && !rd_q) begin
        regs_q[addr_q] <= rx_byte;
        wr_strobe_q    <= 1'b1;
        wr_addr_q      <= addr_q;
      end
    end
  end

  assign miso      = miso_q;
  assign reg0      = regs_q[0];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule
